// File: rtl/exp_golomb_ctrl.sv
// exp_golomb_ctrl: request sequencer around a combinational Exp-Golomb decoder.
// One syntax element (ue/se/te/me) is handled at a time: the bitstream window is
// captured, the decoder is fed from registers, the result is returned on a
// valid/ready response and the consumed length is forwarded to the bit buffer.
module exp_golomb_ctrl #(
    parameter int MAX_LZ = 15,
    parameter int WIN_W  = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_type,
    input  logic [2:0]       req_max_minus1,
    input  logic             req_intra4x4,
    input  logic [WIN_W-1:0] bs_data,
    input  logic             bs_valid,
    output logic             bs_forward_en,
    output logic [4:0]       bs_forward_len,
    output logic [WIN_W-2:0] dec_data,
    output logic [3:0]       dec_zeros,
    output logic [2:0]       dec_max_minus1,
    output logic             dec_te_sel,
    output logic             dec_intra4x4,
    input  logic [15:0]      dec_ue,
    input  logic [15:0]      dec_se,
    input  logic [9:0]       dec_te,
    input  logic [3:0]       dec_cbp_luma,
    input  logic [1:0]       dec_cbp_chroma,
    input  logic [4:0]       dec_len,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [15:0]      rsp_value,
    output logic [5:0]       rsp_cbp,
    output logic [4:0]       rsp_len,
    output logic             rsp_err,
    output logic             err_sticky
);

    localparam logic [1:0] TYPE_UE = 2'd0;
    localparam logic [1:0] TYPE_SE = 2'd1;
    localparam logic [1:0] TYPE_TE = 2'd2;
    localparam logic [1:0] TYPE_ME = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [1:0]       reqType_q,   reqType_d;
    logic [2:0]       maxMinus1_q, maxMinus1_d;
    logic             intra_q,     intra_d;
    logic [WIN_W-1:0] window_q,    window_d;
    logic [3:0]       lz_q,        lz_d;
    logic [15:0]      rspValue_q,  rspValue_d;
    logic [5:0]       rspCbp_q,    rspCbp_d;
    logic [4:0]       rspLen_q,    rspLen_d;
    logic             rspErr_q,    rspErr_d;
    logic             errSticky_q, errSticky_d;

    logic       accept;
    logic [3:0] capLz;
    logic       zeroHi;
    logic       shortTe;
    logic       decErr;
    logic       fwdOk;
    logic       unused_winLsb;

    // The longest legal code is 31 bits, so the window LSB never reaches the decoder.
    assign unused_winLsb = window_q[0];

    assign accept  = req_valid && bs_valid;
    assign zeroHi  = (window_q[WIN_W-1:WIN_W-16] == 16'd0);
    assign shortTe = (reqType_q == TYPE_TE) && (maxMinus1_q <= 3'd1);
    assign decErr  = (zeroHi && !shortTe) || ((reqType_q == TYPE_ME) && (dec_ue > 16'd47));
    assign fwdOk   = !decErr && (dec_len != 5'd0);

    // Count leading zeros of the incoming window's top half, saturating at MAX_LZ.
    always_comb begin
        capLz = 4'(MAX_LZ);
        for (int i = 0; i < 16; i++) begin
            if (bs_data[WIN_W-16+i]) begin
                capLz = 4'(15 - i);
            end
        end
    end

    // State register; an asynchronous reset abandons whatever request was in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: capture, one decode cycle, then hold the response until taken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = DECODE;
            DECODE:  state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Control outputs derived from the current state.
    always_comb begin
        req_ready      = (state_q == IDLE);
        rsp_valid      = (state_q == RESP);
        bs_forward_en  = (state_q == DECODE) && fwdOk;
        bs_forward_len = ((state_q == DECODE) && fwdOk) ? dec_len : 5'd0;
    end

    // Datapath next values: latch the request in IDLE, sample the decoder in DECODE.
    always_comb begin
        reqType_d   = reqType_q;
        maxMinus1_d = maxMinus1_q;
        intra_d     = intra_q;
        window_d    = window_q;
        lz_d        = lz_q;
        rspValue_d  = rspValue_q;
        rspCbp_d    = rspCbp_q;
        rspLen_d    = rspLen_q;
        rspErr_d    = rspErr_q;
        errSticky_d = errSticky_q;
        if ((state_q == IDLE) && accept) begin
            reqType_d   = req_type;
            maxMinus1_d = req_max_minus1;
            intra_d     = req_intra4x4;
            window_d    = bs_data;
            lz_d        = capLz;
        end
        if (state_q == DECODE) begin
            rspValue_d = 16'd0;
            rspCbp_d   = 6'd0;
            if (decErr) begin
                rspLen_d    = 5'd0;
                rspErr_d    = 1'b1;
                errSticky_d = 1'b1;
            end else begin
                rspLen_d = dec_len;
                rspErr_d = 1'b0;
                case (reqType_q)
                    TYPE_UE: rspValue_d = dec_ue;
                    TYPE_SE: rspValue_d = dec_se;
                    TYPE_TE: rspValue_d = {6'd0, dec_te};
                    TYPE_ME: rspCbp_d   = {dec_cbp_chroma, dec_cbp_luma};
                    default: rspValue_d = 16'd0;
                endcase
            end
        end
    end

    // Datapath registers, all cleared by reset (including the sticky error flag).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reqType_q   <= 2'd0;
            maxMinus1_q <= 3'd0;
            intra_q     <= 1'b0;
            window_q    <= '0;
            lz_q        <= 4'd0;
            rspValue_q  <= 16'd0;
            rspCbp_q    <= 6'd0;
            rspLen_q    <= 5'd0;
            rspErr_q    <= 1'b0;
            errSticky_q <= 1'b0;
        end else begin
            reqType_q   <= reqType_d;
            maxMinus1_q <= maxMinus1_d;
            intra_q     <= intra_d;
            window_q    <= window_d;
            lz_q        <= lz_d;
            rspValue_q  <= rspValue_d;
            rspCbp_q    <= rspCbp_d;
            rspLen_q    <= rspLen_d;
            rspErr_q    <= rspErr_d;
            errSticky_q <= errSticky_d;
        end
    end

    assign dec_data       = window_q[WIN_W-1:1];
    assign dec_zeros      = lz_q;
    assign dec_max_minus1 = maxMinus1_q;
    assign dec_te_sel     = (reqType_q == TYPE_TE);
    assign dec_intra4x4   = intra_q;

    assign rsp_value  = rspValue_q;
    assign rsp_cbp    = rspCbp_q;
    assign rsp_len    = rspLen_q;
    assign rsp_err    = rspErr_q;
    assign err_sticky = errSticky_q;

endmodule

// File: tb/tb_exp_golomb_ctrl.sv
// tb_exp_golomb_ctrl: directed and randomized requests against exp_golomb_ctrl.
// The bench plays the combinational decoder and predicts each response from the
// raw bitstream word using the Exp-Golomb rules directly.
module tb_exp_golomb_ctrl;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_type;
    logic [2:0]  req_max_minus1;
    logic        req_intra4x4;
    logic [31:0] bs_data;
    logic        bs_valid;
    logic        bs_forward_en;
    logic [4:0]  bs_forward_len;
    logic [30:0] dec_data;
    logic [3:0]  dec_zeros;
    logic [2:0]  dec_max_minus1;
    logic        dec_te_sel;
    logic        dec_intra4x4;
    logic [15:0] dec_ue;
    logic [15:0] dec_se;
    logic [9:0]  dec_te;
    logic [3:0]  dec_cbp_luma;
    logic [1:0]  dec_cbp_chroma;
    logic [4:0]  dec_len;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_value;
    logic [5:0]  rsp_cbp;
    logic [4:0]  rsp_len;
    logic        rsp_err;
    logic        err_sticky;

    int checks = 0;
    int errors = 0;
    logic stickyExp = 1'b0;

    // coded_block_pattern mapping for me(v), indexed by codeNum: {chroma[1:0], luma[3:0]}
    int intraTab[48] = '{47,31,15,0,23,27,29,30,7,11,13,14,39,43,45,46,
                         16,3,5,10,12,19,21,26,28,35,37,42,44,1,2,4,
                         8,17,18,20,24,6,9,22,25,32,33,34,36,40,38,41};
    int interTab[48] = '{0,16,1,2,4,8,32,3,5,10,12,15,47,7,11,13,
                         14,6,9,31,35,37,42,44,33,34,36,40,39,43,45,46,
                         17,18,20,24,19,21,26,28,23,27,29,30,22,25,38,41};

    exp_golomb_ctrl dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_type       (req_type),
        .req_max_minus1 (req_max_minus1),
        .req_intra4x4   (req_intra4x4),
        .bs_data        (bs_data),
        .bs_valid       (bs_valid),
        .bs_forward_en  (bs_forward_en),
        .bs_forward_len (bs_forward_len),
        .dec_data       (dec_data),
        .dec_zeros      (dec_zeros),
        .dec_max_minus1 (dec_max_minus1),
        .dec_te_sel     (dec_te_sel),
        .dec_intra4x4   (dec_intra4x4),
        .dec_ue         (dec_ue),
        .dec_se         (dec_se),
        .dec_te         (dec_te),
        .dec_cbp_luma   (dec_cbp_luma),
        .dec_cbp_chroma (dec_cbp_chroma),
        .dec_len        (dec_len),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_value      (rsp_value),
        .rsp_cbp        (rsp_cbp),
        .rsp_len        (rsp_len),
        .rsp_err        (rsp_err),
        .err_sticky     (err_sticky)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural combinational decoder fed from the controller's decoder inputs
    logic [31:0] md;
    int mz;
    int mcode;
    int mcbp;
    always_comb begin
        md    = {1'b0, dec_data};
        mz    = int'(dec_zeros);
        mcode = (1 << mz) - 1 + int'((md >> (30 - 2 * mz)) & ((32'd1 << mz) - 32'd1));
        mcbp  = 0;
        if (mcode <= 47) mcbp = dec_intra4x4 ? intraTab[mcode] : interTab[mcode];
        dec_ue         = 16'(mcode);
        dec_se         = (mcode % 2 == 1) ? 16'((mcode + 1) / 2) : 16'(-(mcode / 2));
        dec_te         = 10'(mcode);
        dec_len        = 5'(2 * mz + 1);
        dec_cbp_luma   = 4'(mcbp);
        dec_cbp_chroma = 2'(mcbp >> 4);
        if (dec_te_sel && dec_max_minus1 == 3'd0) begin
            dec_te  = 10'd0;
            dec_len = 5'd0;
        end else if (dec_te_sel && dec_max_minus1 == 3'd1) begin
            dec_te  = {9'd0, ~dec_data[30]};
            dec_len = 5'd1;
        end
    end

    // Reference: expected response straight from the bitstream word and request fields
    task automatic refModel(input logic [1:0] t, input logic [2:0] mm1, input logic intra,
                            input logic [31:0] bs, output logic [15:0] v,
                            output logic [5:0] cbp, output logic [4:0] len, output logic err);
        int lz;
        int code;
        v = 16'd0; cbp = 6'd0; len = 5'd0; err = 1'b0;
        lz = 0;
        while (lz < 32 && bs[31 - lz] == 1'b0) lz++;
        if (t == 2'd2 && mm1 == 3'd0) begin
            len = 5'd0;
        end else if (t == 2'd2 && mm1 == 3'd1) begin
            v   = bs[31] ? 16'd0 : 16'd1;
            len = 5'd1;
        end else if (lz >= 16) begin
            err = 1'b1;
        end else begin
            code = int'(bs >> (31 - 2 * lz)) - 1;
            len  = 5'(2 * lz + 1);
            case (t)
                2'd0: v = 16'(code);
                2'd1: v = (code & 1) ? 16'((code >> 1) + 1) : 16'(0 - (code >> 1));
                2'd2: v = 16'(code & 32'h3FF);
                default: begin
                    if (code > 47) begin
                        err = 1'b1;
                        len = 5'd0;
                    end else begin
                        cbp = 6'(intra ? intraTab[code] : interTab[code]);
                    end
                end
            endcase
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One complete transaction: request, decode-cycle checks, response held for 'hold' extra cycles
    task automatic applyStimulus(input logic [1:0] t, input logic [2:0] mm1, input logic intra,
                                 input logic [31:0] bs, input int hold);
        logic [15:0] ev;
        logic [5:0]  ecbp;
        logic [4:0]  elen;
        logic        eerr;
        logic        efwd;
        refModel(t, mm1, intra, bs, ev, ecbp, elen, eerr);
        efwd = !eerr && (elen != 5'd0);
        @(negedge clk);
        req_type = t; req_max_minus1 = mm1; req_intra4x4 = intra;
        bs_data = bs; bs_valid = 1'b1; req_valid = 1'b1;
        checkOutput("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0; bs_valid = 1'b0; bs_data = $urandom;
        @(negedge clk);
        checkOutput("fwd_en", 32'(bs_forward_en), 32'(efwd));
        checkOutput("fwd_len", 32'(bs_forward_len), efwd ? 32'(elen) : 32'd0);
        checkOutput("rsp_valid_decode", 32'(rsp_valid), 32'd0);
        checkOutput("req_ready_decode", 32'(req_ready), 32'd0);
        if (eerr) stickyExp = 1'b1;
        @(negedge clk);
        for (int i = 0; i <= hold; i++) begin
            checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("rsp_value", 32'(rsp_value), 32'(ev));
            checkOutput("rsp_cbp", 32'(rsp_cbp), 32'(ecbp));
            checkOutput("rsp_len", 32'(rsp_len), 32'(elen));
            checkOutput("rsp_err", 32'(rsp_err), 32'(eerr));
            checkOutput("err_sticky", 32'(err_sticky), 32'(stickyExp));
            checkOutput("req_ready_resp", 32'(req_ready), 32'd0);
            checkOutput("fwd_en_resp", 32'(bs_forward_en), 32'd0);
            if (i < hold) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        checkOutput("rsp_valid_done", 32'(rsp_valid), 32'd0);
        checkOutput("req_ready_done", 32'(req_ready), 32'd1);
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_fwd_en", 32'(bs_forward_en), 32'd0);
        checkOutput("rst_fwd_len", 32'(bs_forward_len), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_value", 32'(rsp_value), 32'd0);
        checkOutput("rst_rsp_cbp", 32'(rsp_cbp), 32'd0);
        checkOutput("rst_rsp_len", 32'(rsp_len), 32'd0);
        checkOutput("rst_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("rst_err_sticky", 32'(err_sticky), 32'd0);
        checkOutput("rst_dec_data", 32'(dec_data), 32'd0);
        checkOutput("rst_dec_zeros", 32'(dec_zeros), 32'd0);
    endtask

    initial begin
        logic [31:0] rbs;
        int          rlz;
        reset_n = 1'b0; req_valid = 1'b0; req_type = 2'd0; req_max_minus1 = 3'd0;
        req_intra4x4 = 1'b0; bs_data = 32'd0; bs_valid = 1'b0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkResetOutputs();
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("req_ready_after_reset", 32'(req_ready), 32'd1);

        // Directed elements
        applyStimulus(2'd0, 3'd0, 1'b0, 32'h8000_0000, 0);
        applyStimulus(2'd1, 3'd0, 1'b0, 32'h2000_0000, 0);
        applyStimulus(2'd1, 3'd0, 1'b0, 32'h2800_0000, 0);
        applyStimulus(2'd2, 3'd1, 1'b0, 32'h0000_0000, 0);
        applyStimulus(2'd2, 3'd1, 1'b0, 32'h8000_0000, 0);
        applyStimulus(2'd2, 3'd0, 1'b0, 32'h1234_5678, 0);
        applyStimulus(2'd2, 3'd5, 1'b0, 32'h1800_0000, 1);
        applyStimulus(2'd3, 3'd0, 1'b1, 32'h2000_0000, 0);
        applyStimulus(2'd3, 3'd0, 1'b0, 32'h8000_0000, 0);
        applyStimulus(2'd0, 3'd0, 1'b0, 32'h0001_FFFF, 0);
        applyStimulus(2'd3, 3'd0, 1'b0, 32'h0040_0000, 0);

        // Request without a valid window must wait in IDLE
        @(negedge clk);
        req_valid = 1'b1; bs_valid = 1'b0; bs_data = 32'h8000_0000;
        repeat (3) begin
            @(negedge clk);
            checkOutput("wait_req_ready", 32'(req_ready), 32'd1);
            checkOutput("wait_fwd_en", 32'(bs_forward_en), 32'd0);
            checkOutput("wait_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        req_valid = 1'b0;

        // Malformed code, response held for 5 cycles
        applyStimulus(2'd0, 3'd0, 1'b0, 32'h0000_FFFF, 5);
        applyStimulus(2'd1, 3'd0, 1'b0, 32'h0600_0000, 0);

        // Reset asserted in the decode cycle
        @(negedge clk);
        req_type = 2'd0; bs_data = 32'h4000_0000; bs_valid = 1'b1; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0; bs_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        stickyExp = 1'b0;
        #1;
        checkResetOutputs();
        @(negedge clk);
        checkResetOutputs();
        reset_n = 1'b1;
        applyStimulus(2'd0, 3'd0, 1'b0, 32'h4000_0000, 0);

        // Randomized elements
        for (int n = 0; n < 60; n++) begin
            rlz = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 5)) : int'($urandom_range(0, 17));
            rbs = $urandom;
            rbs = (rbs & (32'hFFFF_FFFF >> rlz)) | (32'h8000_0000 >> rlz);
            applyStimulus(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          rbs, int'($urandom_range(0, 2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
